// File: rtl/rx_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rx_frame_sequencer
//  Brief    : Serial receive controller. Detects the start bit, samples data
//             bits LSB first at mid-bit, checks the stop bit and delivers
//             each byte through a valid/ready handshake. Reports frame
//             errors (one-cycle pulse) and overruns (sticky).
//  Revision : 1.0 - initial release
// ============================================================================
module rx_frame_sequencer #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    input  logic                 rx_ready,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int C_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int C_BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [C_CNT_W-1:0] C_HALF_LAST = C_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [C_CNT_W-1:0] C_FULL_LAST = C_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [C_BIT_W-1:0] C_LAST_BIT  = C_BIT_W'(DATA_BITS - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);
    localparam logic [C_BIT_W-1:0] C_BIT_ONE   = C_BIT_W'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [C_CNT_W-1:0]   r_clk_cnt;
    logic [C_BIT_W-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic w_half_done;
    logic w_bit_done;
    logic w_clk_inc;
    logic w_clk_clr;
    logic w_bit_inc;
    logic w_bit_clr;
    logic w_shift_en;
    logic w_good_stop;
    logic w_bad_stop;
    logic w_accept;
    logic w_load;
    logic w_drop;

    assign w_half_done = (r_clk_cnt == C_HALF_LAST);
    assign w_bit_done  = (r_clk_cnt == C_FULL_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: start qualification, bit walk, stop check, break wait
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!rx_in) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                if (w_half_done) begin
                    w_next_state = rx_in ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_done && (r_bit_cnt == C_LAST_BIT)) begin
                    w_next_state = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_done) begin
                    w_next_state = rx_in ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rx_in) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output decode: counter/shift strobes, stop-bit verdict and busy
    always_comb begin
        w_clk_inc   = 1'b0;
        w_clk_clr   = 1'b0;
        w_bit_inc   = 1'b0;
        w_bit_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_good_stop = 1'b0;
        w_bad_stop  = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_START: begin
                if (w_half_done) begin
                    w_clk_clr = 1'b1;
                end else begin
                    w_clk_inc = 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_clk_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == C_LAST_BIT) begin
                        w_bit_clr = 1'b1;
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end else begin
                    w_clk_inc = 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_done) begin
                    w_clk_clr   = 1'b1;
                    w_good_stop = rx_in;
                    w_bad_stop  = ~rx_in;
                end else begin
                    w_clk_inc = 1'b1;
                end
            end
            default: begin
                // IDLE and BREAK keep both counters parked at zero
                w_clk_clr = 1'b1;
                w_bit_clr = 1'b1;
            end
        endcase
    end

    // Bit timing counters and LSB-first shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (w_clk_clr) begin
                r_clk_cnt <= '0;
            end else if (w_clk_inc) begin
                r_clk_cnt <= r_clk_cnt + C_CNT_ONE;
            end
            if (w_bit_clr) begin
                r_bit_cnt <= '0;
            end else if (w_bit_inc) begin
                r_bit_cnt <= r_bit_cnt + C_BIT_ONE;
            end
            if (w_shift_en) begin
                r_shift <= {rx_in, r_shift[DATA_BITS-1:1]};
            end
        end
    end

    // A good stop may load only when the buffer is empty or drained this cycle
    assign w_accept = r_rx_valid & rx_ready;
    assign w_load   = w_good_stop & (~r_rx_valid | rx_ready);
    assign w_drop   = w_good_stop & r_rx_valid & ~rx_ready;

    // Output buffer, handshake and error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_load) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (w_accept) begin
                r_rx_valid <= 1'b0;
            end
            // A new drop outranks a simultaneous clear
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (err_clr) begin
                r_overrun <= 1'b0;
            end
            r_frame_err <= w_bad_stop;
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: doc/rx_frame_sequencer.md
Name: rx_frame_sequencer

Overview:
- Complete serial-receive controller for the rx device. Owns the per-bit clock counter, bit counter and shift register that a bare rx control FSM leaves external.
- Detects the start bit, samples data bits at mid-bit, checks the stop bit, and delivers each byte through a valid/ready handshake.
- Sits between the synchronised serial input pin and the consumer logic. Reports frame errors and overruns.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first; legal range 5..9.
- CLKS_PER_BIT, 8, clk cycles per serial bit; must be even and >= 4.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- rx_in  in  1  serial line, already synchronised, idle high
- rx_ready  in  1  consumer accepts rx_data when rx_valid=1
- err_clr  in  1  clears the sticky overrun flag
- rx_data  out  DATA_BITS  received byte, registered
- rx_valid  out  1  rx_data holds an unaccepted byte
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low
- overrun  out  1  sticky flag: a completed byte was dropped
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, clk_cnt=0, bit_cnt=0, shift reg=0, rx_data=0, rx_valid=0, frame_err=0, overrun=0. Reset mid-frame aborts the frame; no partial data is delivered.
- Counter widths: clk_cnt is $clog2(CLKS_PER_BIT) bits; bit_cnt is $clog2(DATA_BITS) bits, minimum 1.
- Timing reference t0: the edge at which IDLE samples rx_in=0.

State machine:
- IDLE: hold clk_cnt=0 and bit_cnt=0. On rx_in=0, go to START.
- START: increment clk_cnt each cycle. When clk_cnt==CLKS_PER_BIT/2-1 (mid start bit, edge t0+CLKS_PER_BIT/2):
  - rx_in=0: go to DATA and clear clk_cnt.
  - rx_in=1: treat as a glitch and go to IDLE.
- DATA: clk_cnt counts 0..CLKS_PER_BIT-1. When clk_cnt==CLKS_PER_BIT-1:
  - shift rx_in into the MSB of the shift reg (shift right);
  - clear clk_cnt and increment bit_cnt;
  - if bit_cnt==DATA_BITS-1, clear bit_cnt and go to STOP.
- STOP: when clk_cnt==CLKS_PER_BIT-1, sample rx_in:
  - rx_in=1 (good stop): run the delivery rule below, then go to IDLE.
  - rx_in=0: pulse frame_err=1 in the next cycle, discard the byte, go to BREAK.
- BREAK: wait for rx_in=1, then go to IDLE. No start detection happens while the line stays low.

Sample timing (defaults, CLKS_PER_BIT=8, DATA_BITS=8):
- Data bit k (k=1..DATA_BITS) is sampled at t0+CLKS_PER_BIT/2+k*CLKS_PER_BIT.
- Stop bit is sampled at t0+CLKS_PER_BIT/2+(DATA_BITS+1)*CLKS_PER_BIT = t0+76.
- rx_valid rises at t0+77.

Delivery rule (evaluated in the good-stop sample cycle):
- Output buffer is free (rx_valid=0, or rx_valid&rx_ready this cycle): load rx_data, and rx_valid=1 next cycle.
- rx_valid=1 and rx_ready=0: drop the new byte, keep the old rx_data, set overrun=1 next cycle.
- Simultaneous accept and load: the new byte replaces the old one, rx_valid stays 1, no overrun.

Handshake and flags:
- rx_valid and rx_data are held stable until rx_valid&rx_ready. rx_valid then falls next cycle unless a new load occurs.
- overrun stays set until err_clr=1. If an overrun event and err_clr occur in the same cycle, set wins.
- frame_err is exactly one cycle wide per bad frame and does not affect rx_valid or rx_data.
- rx_ready and err_clr are ignored while rst=1.

Test Plan:
- 0xA5 framed (start 0, bits LSB first, stop 1), CLKS_PER_BIT=8, rx_ready=1 -> rx_valid=1 only at t0+77, rx_data=0xA5, busy low from t0+77.
- rx_in low for 2 cycles then high -> START aborts at t0+4, busy high only t0+1..t0+4, no rx_valid, no frame_err.
- 0x3C with stop bit 0, line held low 20 more cycles -> frame_err=1 for exactly one cycle at t0+77, rx_valid stays 0, state BREAK until rx_in=1, then the next 0x81 frame is received correctly.
- Frames 0x11 then 0x22 with rx_ready=0 -> rx_data stays 0x11, overrun=1 after the second stop sample; err_clr pulse -> overrun=0 next cycle; err_clr coincident with a third dropped frame -> overrun remains 1.
- Frame 0x11 pending; rx_ready=1 exactly in the stop-sample cycle of frame 0x22 -> rx_data=0x22 next cycle, rx_valid continuous 1, overrun=0.
- rst=1 for 1 cycle during DATA bit 4 of 0xF0 -> all outputs 0 and busy=0 next cycle; a following 0x5A frame is received as 0x5A at t0'+77.
